// File: rtl/maxpool_2x2_reader.sv
// 2x2 stride-2 unsigned max-pool over a row-major 8-bit image held in an external
// dual-read pixel buffer; emits one pooled value per valid/ready handshake in raster order.
module maxpool_2x2_reader #(
  parameter int ROWS = 28,
  parameter int COLS = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [9:0] rd_addr1,
  output logic [9:0] rd_addr2,
  input  logic [7:0] rd_data1,
  input  logic [7:0] rd_data2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, FETCH_TOP, FETCH_BOT, EMIT, DONE} state_t;

  localparam logic [9:0] COLS_W   = 10'(COLS);
  localparam logic [9:0] PC_LAST  = 10'(COLS/2 - 1);
  localparam logic [7:0] IDX_LAST = 8'((ROWS/2)*(COLS/2) - 1);

  state_t     r_state;
  logic [9:0] r_pr, r_pc;
  logic [7:0] r_top, r_out_data, r_out_idx;
  logic       r_out_valid, r_busy, r_done;

  logic [9:0] w_top, w_bot;
  logic [7:0] w_m12, w_m4;

  // Top-left pixel of the current window; bottom row is one image row further.
  assign w_top = ((r_pr * COLS_W) << 1) + (r_pc << 1);
  assign w_bot = w_top + COLS_W;
  assign w_m12 = (rd_data1 > rd_data2) ? rd_data1 : rd_data2;
  assign w_m4  = (r_top > w_m12) ? r_top : w_m12;

  always_comb begin
    rd_addr1 = '0;
    rd_addr2 = '0;
    case (r_state)
      FETCH_TOP: begin rd_addr1 = w_top; rd_addr2 = w_top + 10'd1; end
      FETCH_BOT: begin rd_addr1 = w_bot; rd_addr2 = w_bot + 10'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pr        <= '0;
      r_pc        <= '0;
      r_top       <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_pr      <= '0;
          r_pc      <= '0;
          r_out_idx <= '0;
          r_busy    <= 1'b1;
          r_state   <= FETCH_TOP;
        end
        FETCH_TOP: begin
          r_top   <= w_m12;
          r_state <= FETCH_BOT;
        end
        FETCH_BOT: begin
          r_out_data  <= w_m4;
          r_out_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: if (out_ready) begin
          r_out_valid <= 1'b0;
          if (r_out_idx == IDX_LAST) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            if (r_pc == PC_LAST) begin
              r_pc <= '0;
              r_pr <= r_pr + 10'd1;
            end else begin
              r_pc <= r_pc + 10'd1;
            end
            r_out_idx <= r_out_idx + 8'd1;
            r_state   <= FETCH_TOP;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool_2x2_reader.sv
// Scoreboarded bench for maxpool_2x2_reader: stimulus queues expected {idx,data},
// a negedge monitor pops on each handshake; directed cycle checks cover timing corners.
module tb_maxpool_2x2_reader;
  localparam int ROWS = 28, COLS = 28, NRES = (ROWS/2)*(COLS/2);

  logic       clk = 0, rst = 0, start = 0, out_ready = 1;
  logic [9:0] rd_addr1, rd_addr2;
  logic [7:0] rd_data1, rd_data2, out_data, out_idx;
  logic       out_valid, busy, done;
  logic [7:0] mem [0:1023];

  int errors = 0, checks = 0;
  int cyc = 0, last_hs_cyc = -10, hs_cnt = 0, done_cnt = 0;
  logic [15:0] sbq[$];

  always #5 clk = ~clk;

  assign rd_data1 = mem[rd_addr1];
  assign rd_data2 = mem[rd_addr2];

  maxpool_2x2_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel pattern (i%5)+1 and its pooled value, from the image definition.
  function automatic int pool_a(input int k);
    int pr, pc, m, a;
    pr = k / (COLS/2); pc = k % (COLS/2); m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        a = (2*pr + dr)*COLS + 2*pc + dc;
        if ((a % 5) + 1 > m) m = (a % 5) + 1;
      end
    return m;
  endfunction

  // Monitor: handshakes, done placement, exclusivity.
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (rst && out_valid && out_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (sbq.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("sb_idx", int'(out_idx), int'(e[15:8]));
        chk("sb_data", int'(out_data), int'(e[7:0]));
      end
    end
    if (rst && done) begin
      done_cnt++;
      chk("done_after_last_hs", cyc - last_hs_cyc, 1);
      chk("done_last_idx", int'(out_idx), NRES - 1);
    end
    if (done && out_valid) chk("done_valid_excl", 1, 0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic push_a();
    for (int k = 0; k < NRES; k++) sbq.push_back({8'(k), 8'(pool_a(k))});
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(out_valid && out_idx == 8'(idx)) && n < 5000) begin step(); n++; end
    chk($sformatf("reach_idx_%0d", idx), int'(n < 5000), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin step(); n++; end
    chk("done_seen", int'(done), 1);
    chk("busy_at_done", int'(busy), 1);
    step();
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("queue_empty", sbq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i % 5) + 1);
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr1", int'(rd_addr1), 0);
    chk("rst_data", int'(out_data), 0);
    step(); step();
    rst = 1;
    step();

    // First results with exact cycle timing, then rest of frame.
    push_a(); hs_cnt = 0;
    pulse_start();
    chk("c1_addr1", int'(rd_addr1), 0);  chk("c1_addr2", int'(rd_addr2), 1);
    chk("c1_busy", int'(busy), 1);
    step();
    chk("c2_addr1", int'(rd_addr1), 28); chk("c2_addr2", int'(rd_addr2), 29);
    chk("c2_valid", int'(out_valid), 0);
    step();
    chk("c3_valid", int'(out_valid), 1);
    chk("c3_data", int'(out_data), 5);   chk("c3_idx", int'(out_idx), 0);
    step();
    chk("c4_addr1", int'(rd_addr1), 2);  chk("c4_addr2", int'(rd_addr2), 3);
    step();
    chk("c5_addr1", int'(rd_addr1), 30); chk("c5_addr2", int'(rd_addr2), 31);
    step();
    chk("c6_data", int'(out_data), 4);   chk("c6_idx", int'(out_idx), 1);
    wait_done();
    chk("frame1_handshakes", hs_cnt, NRES);
    chk("frame1_done_cnt", done_cnt, 1);

    // Backpressure at idx 7, then ignored start at idx 10.
    push_a(); hs_cnt = 0;
    pulse_start();
    wait_idx(7);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx", int'(out_idx), 7);
      chk("bp_data", int'(out_data), pool_a(7));
      chk("bp_addr1", int'(rd_addr1), 0);
    end
    out_ready = 1;
    wait_idx(10);
    pulse_start();
    wait_idx(11);
    wait_done();
    chk("frame2_handshakes", hs_cnt, NRES);
    chk("frame2_done_cnt", done_cnt, 2);

    // Mid-frame async reset at idx 50.
    push_a();
    pulse_start();
    wait_idx(50);
    rst = 0;
    #1;
    chk("mr_valid", int'(out_valid), 0);
    chk("mr_idx", int'(out_idx), 0);
    chk("mr_data", int'(out_data), 0);
    chk("mr_busy", int'(busy), 0);
    step();
    rst = 1;
    sbq.delete();
    for (int i = 0; i < 10; i++) step();
    chk("mr_idle_busy", int'(busy), 0);
    chk("mr_no_done", done_cnt, 2);
    push_a(); hs_cnt = 0;
    pulse_start(); step(); step();
    chk("mr_restart_idx", int'(out_idx), 0);
    chk("mr_restart_data", int'(out_data), 5);
    wait_done();
    chk("frame3_handshakes", hs_cnt, NRES);

    // All 0xFF with a single zero: pooling must ignore the lone zero.
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    mem[29] = 8'h00;
    for (int k = 0; k < NRES; k++) sbq.push_back({8'(k), 8'd255});
    pulse_start();
    wait_done();

    // All zero with a single 0xFF in window 0's bottom-right.
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[29] = 8'hFF;
    sbq.push_back({8'd0, 8'd255});
    for (int k = 1; k < NRES; k++) sbq.push_back({8'(k), 8'd0});
    pulse_start();
    wait_done();
    chk("total_done_cnt", done_cnt, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
